// File: rtl/search_pkg.sv
// search_pkg: shared constants and types for the search scheduler slice.
//   NUM_ELEM/ELEM_W  : element count and width fed to the min-search engine
//   LOC_W/CYC_W      : engine result index and cycle-count widths
//   LOC_NONE/CYC_NONE: result codes returned when the engine never finishes
//   TIMEOUT_MAX      : WAIT-state watchdog limit (used with SEARCH_TIMEOUT_EN)
//   state_e          : scheduler FSM states
package search_pkg;

    localparam int unsigned NUM_ELEM    = 10;
    localparam int unsigned ELEM_W      = 7;
    localparam int unsigned LOC_W       = 4;
    localparam int unsigned CYC_W       = 7;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned A_W         = NUM_ELEM * ELEM_W;
    localparam int unsigned TIMEOUT_MAX = 1023;
    localparam int unsigned WD_W        = 10;

    localparam logic [LOC_W-1:0] LOC_NONE = 4'hF;
    localparam logic [CYC_W-1:0] CYC_NONE = 7'h7F;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        ACK,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req      : per-requester request vector
//   ptr      : index of the last winner; the search starts at ptr+1 (modulo)
//   grant    : one-hot winner (all zero when req is zero)
//   grant_id : index of the winner
//   valid    : at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               valid
);

    logic [ID_W-1:0] cand;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        valid    = 1'b0;
        cand     = '0;
        // Visit ptr+1, ptr+2, ... ptr+NUM_REQ; the first hit wins.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant_id    = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/search_scheduler.sv
// search_scheduler: shares one minimum-search engine among NUM_REQ requesters.
// A round-robin grant selects a requester, its 10 elements are collected into
// eng_a, the engine is started, its result is captured on done, ACKed, and
// returned through a valid/ready response.
//
// Ports:
//   clk, reset (async, active-low)
//   req/gnt                 : per-requester request and registered one-hot grant
//   elem_valid/elem_data    : serial element stream from the granted requester
//   eng_a, eng_start, eng_ack, eng_done, eng_location, eng_cycles : engine side
//   rsp_valid/rsp_ready, rsp_id, rsp_location, rsp_cycles         : response
//   rsp_err (only with SEARCH_TIMEOUT_EN) : response produced by the watchdog
//   busy                    : FSM is not IDLE
//
// Build option SEARCH_TIMEOUT_EN adds a 10-bit WAIT watchdog and rsp_err.
module search_scheduler
    import search_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    input  logic               elem_valid,
    input  logic [ELEM_W-1:0]  elem_data,
    output logic [A_W-1:0]     eng_a,
    output logic               eng_start,
    output logic               eng_ack,
    input  logic               eng_done,
    input  logic [LOC_W-1:0]   eng_location,
    input  logic [CYC_W-1:0]   eng_cycles,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [LOC_W-1:0]   rsp_location,
    output logic [CYC_W-1:0]   rsp_cycles,
`ifdef SEARCH_TIMEOUT_EN
    output logic               rsp_err,
`endif
    output logic               busy
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [A_W-1:0]     eng_a_q, eng_a_d;
    logic [LOC_W-1:0]   loc_q, loc_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_id;
    logic               arb_valid;

    logic req_kept;
    logic last_elem;
    logic timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req      (req),
        .ptr      (ptr_q),
        .grant    (arb_gnt),
        .grant_id (arb_id),
        .valid    (arb_valid)
    );

    // Granted requester still asking; used to abort a LOAD.
    assign req_kept  = |(req & gnt_q);
    assign last_elem = elem_valid && (cnt_q == CNT_W'(NUM_ELEM - 1));

`ifdef SEARCH_TIMEOUT_EN
    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // Fires on the 1023rd consecutive WAIT cycle without done.
    assign timeout = (state_q == WAIT) && !eng_done && (wd_q == WD_W'(TIMEOUT_MAX - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q <= (state_q == WAIT) ? wd_q + 1'b1 : '0;
            if ((state_q == WAIT) && eng_done) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end else if ((state_q == RESP) && rsp_ready) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_valid) state_d = LOAD;
            LOAD: begin
                if (!req_kept) begin
                    state_d = IDLE;
                end else if (last_elem) begin
                    state_d = START;
                end
            end
            START:   state_d = WAIT;
            WAIT:    if (eng_done || timeout) state_d = ACK;
            ACK:     state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; all low while reset is asserted.
    always_comb begin
        eng_start = (state_q == START);
        eng_ack   = (state_q == ACK);
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
`ifdef SEARCH_TIMEOUT_EN
        rsp_err   = err_q && (state_q == RESP);
`endif
    end

    assign gnt          = gnt_q;
    assign eng_a        = eng_a_q;
    assign rsp_id       = gid_q;
    assign rsp_location = loc_q;
    assign rsp_cycles   = cyc_q;

    // Datapath next-state.
    always_comb begin
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        eng_a_d = eng_a_q;
        loc_d   = loc_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d = arb_gnt;
                    gid_d = arb_id;
                    ptr_d = arb_id;
                    cnt_d = '0;
                end
            end
            LOAD: begin
                if (!req_kept) begin
                    // Abort: pointer keeps this requester so the next search skips past it.
                    gnt_d = '0;
                    cnt_d = '0;
                end else if (elem_valid) begin
                    for (int k = 0; k < NUM_ELEM; k++) begin
                        if (cnt_q == CNT_W'(k)) eng_a_d[k*ELEM_W +: ELEM_W] = elem_data;
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (eng_done) begin
                    loc_d = eng_location;
                    cyc_d = eng_cycles;
                end else if (timeout) begin
                    loc_d = LOC_NONE;
                    cyc_d = CYC_NONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    gnt_d = '0;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= ID_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
            eng_a_q <= '0;
            loc_q   <= '0;
            cyc_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            eng_a_q <= eng_a_d;
            loc_q   <= loc_d;
            cyc_q   <= cyc_d;
        end
    end

endmodule

// File: tb/tb_search_scheduler.sv
// tb_search_scheduler: directed bench for search_scheduler with a small
// min-search engine model and a response scoreboard.
module tb_search_scheduler;
    import search_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ-1:0] gnt;
    logic               elem_valid = 1'b0;
    logic [6:0]         elem_data = '0;
    logic [69:0]        eng_a;
    logic               eng_start, eng_ack;
    logic               eng_done;
    logic [3:0]         eng_location;
    logic [6:0]         eng_cycles;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [ID_W-1:0]    rsp_id;
    logic [3:0]         rsp_location;
    logic [6:0]         rsp_cycles;
    logic               busy;
`ifdef SEARCH_TIMEOUT_EN
    logic               rsp_err;
`endif

    search_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .gnt          (gnt),
        .elem_valid   (elem_valid),
        .elem_data    (elem_data),
        .eng_a        (eng_a),
        .eng_start    (eng_start),
        .eng_ack      (eng_ack),
        .eng_done     (eng_done),
        .eng_location (eng_location),
        .eng_cycles   (eng_cycles),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_location (rsp_location),
        .rsp_cycles   (rsp_cycles),
`ifdef SEARCH_TIMEOUT_EN
        .rsp_err      (rsp_err),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] loc;
        logic [6:0] cyc;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_cmp = 0, n_err = 0;
    int         n_rsp = 0, n_start = 0, n_ack = 0, n_valid = 0;
    logic [6:0] el[10];
    int         eng_lat = 3;
    logic       last_start;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First index of the minimum element.
    function automatic logic [3:0] min_of_a(input logic [69:0] a);
        logic [6:0] best;
        min_of_a = 4'd0;
        best = a[6:0];
        for (int k = 1; k < 10; k++) begin
            if (a[k*7 +: 7] < best) begin
                best = a[k*7 +: 7];
                min_of_a = 4'(k);
            end
        end
    endfunction

    function automatic logic [3:0] exp_loc();
        logic [6:0] best;
        exp_loc = 4'd0;
        best = el[0];
        for (int k = 1; k < 10; k++) begin
            if (el[k] < best) begin
                best = el[k];
                exp_loc = 4'(k);
            end
        end
    endfunction

    // Engine model: after START, raises done eng_lat cycles later (never if 0); ACK drops done.
    logic eng_run;
    int   eng_ctr;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_done     <= 1'b0;
            eng_location <= '0;
            eng_cycles   <= '0;
            eng_run      <= 1'b0;
            eng_ctr      <= 0;
        end else begin
            if (eng_start) begin
                eng_run <= 1'b1;
                eng_ctr <= 0;
            end else if (eng_run && eng_lat != 0) begin
                eng_ctr <= eng_ctr + 1;
                if (eng_ctr + 1 == eng_lat) begin
                    eng_run      <= 1'b0;
                    eng_done     <= 1'b1;
                    eng_location <= min_of_a(eng_a);
                    eng_cycles   <= 7'(eng_ctr + 1);
                end
            end
            if (eng_ack) eng_done <= 1'b0;
        end
    end

    // Monitor: protocol invariants and scoreboard pop on each response handshake.
    always @(negedge clk) begin
        if (reset) begin
            check("gnt_onehot0", 70'($onehot0(gnt)), 70'd1);
            check("start_ack_excl", 70'(eng_start & eng_ack), 70'd0);
            if (eng_start) n_start++;
            if (eng_ack) n_ack++;
            if (rsp_valid) n_valid++;
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 70'(sb.size() != 0), 70'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rsp_id", 70'(rsp_id), 70'(mon_e.id));
                    check("rsp_location", 70'(rsp_location), 70'(mon_e.loc));
                    check("rsp_cycles", 70'(rsp_cycles), 70'(mon_e.cyc));
`ifdef SEARCH_TIMEOUT_EN
                    check("rsp_err", 70'(rsp_err), 70'(mon_e.err));
`endif
                end
                n_rsp++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [3:0] loc, input logic [6:0] cyc,
                        input logic err);
        exp_t e;
        e.id  = id;
        e.loc = loc;
        e.cyc = cyc;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_gnt(input int id);
        int t;
        logic [NUM_REQ-1:0] g;
        t = 0;
        g = '0;
        g[id] = 1'b1;
        while (gnt == '0 && t < 20) begin
            tick();
            t++;
        end
        check("gnt_id", 70'(gnt), 70'(g));
    endtask

    task automatic send_elems(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            elem_valid = 1'b1;
            elem_data  = el[k];
            tick();
            elem_valid = 1'b0;
            if (k == 9) last_start = eng_start;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_rsp(input int budget);
        int n0, t;
        n0 = n_rsp;
        t = 0;
        while (n_rsp == n0 && t < budget) begin
            tick();
            t++;
        end
        check("rsp_count", 70'(n_rsp - n0), 70'd1);
        check("idle_after_rsp", 70'({busy, gnt}), 70'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req = '0;
        elem_valid = 1'b0;
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int s0, a0, v0, t;

        // Reset values.
        tick();
        check("rst_gnt", 70'(gnt), 70'd0);
        check("rst_eng_a", eng_a, 70'd0);
        check("rst_eng_start", 70'(eng_start), 70'd0);
        check("rst_eng_ack", 70'(eng_ack), 70'd0);
        check("rst_rsp_valid", 70'(rsp_valid), 70'd0);
        check("rst_rsp_id", 70'(rsp_id), 70'd0);
        check("rst_rsp_location", 70'(rsp_location), 70'd0);
        check("rst_rsp_cycles", 70'(rsp_cycles), 70'd0);
        check("rst_busy", 70'(busy), 70'd0);
`ifdef SEARCH_TIMEOUT_EN
        check("rst_rsp_err", 70'(rsp_err), 70'd0);
`endif
        reset = 1'b1;
        tick();

        // 1: single transaction, back-to-back elements.
        el = '{7'd50, 7'd40, 7'd30, 7'd20, 7'd10, 7'd60, 7'd70, 7'd80, 7'd90, 7'd100};
        rsp_ready = 1'b1;
        s0 = n_start;
        a0 = n_ack;
        req = 4'b0001;
        tick();
        check("t1_gnt", 70'(gnt), 70'b0001);
        push(0, 4'd4, 7'd3, 1'b0);
        send_elems(10, 0);
        check("t1_start_after_last", 70'(last_start), 70'd1);
        check("t1_slot4", 70'(eng_a[34:28]), 70'd10);
        check("t1_slot9", 70'(eng_a[69:63]), 70'd100);
        wait_rsp(40);
        req = '0;
        check("t1_start_pulses", 70'(n_start - s0), 70'd1);
        check("t1_ack_pulses", 70'(n_ack - a0), 70'd1);

        // 2: all requesting, round-robin order 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(i % 4);
            for (int k = 0; k < 10; k++) el[k] = 7'($urandom_range(0, 127));
            eng_lat = 1 + i;
            push(i % 4, exp_loc(), 7'(eng_lat), 1'b0);
            send_elems(10, i % 2);
            check("t2_start_after_last", 70'(last_start), 70'd1);
            wait_rsp(60);
            if (i == 4) req = '0;
        end

        // 3: requester 2 aborts mid-LOAD; next grant goes past it.
        do_reset();
        eng_lat = 2;
        req = 4'b0100;
        wait_gnt(2);
        s0 = n_start;
        v0 = n_valid;
        send_elems(4, 0);
        req = '0;
        tick();
        check("t3_abort_gnt", 70'(gnt), 70'd0);
        check("t3_abort_busy", 70'(busy), 70'd0);
        tick();
        tick();
        check("t3_no_start", 70'(n_start - s0), 70'd0);
        check("t3_no_valid", 70'(n_valid - v0), 70'd0);
        req = 4'b1001;
        wait_gnt(3);
        el = '{7'd9, 7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd1};
        push(3, 4'd8, 7'd2, 1'b0);
        send_elems(10, 0);
        wait_rsp(40);
        req = '0;

        // 4: back-pressure in RESP; no new grant while held.
        rsp_ready = 1'b0;
        req = 4'b0001;
        wait_gnt(0);
        el = '{7'd100, 7'd90, 7'd3, 7'd80, 7'd70, 7'd60, 7'd3, 7'd50, 7'd40, 7'd30};
        push(0, 4'd2, 7'd2, 1'b0);
        send_elems(10, 0);
        t = 0;
        while (!rsp_valid && t < 40) begin
            tick();
            t++;
        end
        req = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", 70'(rsp_valid), 70'd1);
            check("t4_hold_id", 70'(rsp_id), 70'd0);
            check("t4_hold_loc", 70'(rsp_location), 70'd2);
            check("t4_hold_gnt", 70'(gnt), 70'b0001);
        end
        rsp_ready = 1'b1;
        wait_rsp(3);
        req = '0;

        // 5: asynchronous reset during WAIT.
        eng_lat = 0;
        req = 4'b0001;
        wait_gnt(0);
        for (int k = 0; k < 10; k++) el[k] = 7'(k + 20);
        push(0, 4'd0, 7'd0, 1'b0);
        send_elems(10, 0);
        tick();
        tick();
        check("t5_busy_before", 70'(busy), 70'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_gnt", 70'(gnt), 70'd0);
        check("t5_rst_start", 70'(eng_start), 70'd0);
        check("t5_rst_ack", 70'(eng_ack), 70'd0);
        check("t5_rst_valid", 70'(rsp_valid), 70'd0);
        check("t5_rst_busy", 70'(busy), 70'd0);
        sb.delete();
        req = '0;
        tick();
        reset = 1'b1;
        eng_lat = 2;
        req = 4'b0010;
        wait_gnt(1);
        el = '{7'd5, 7'd6, 7'd7, 7'd8, 7'd9, 7'd10, 7'd11, 7'd12, 7'd13, 7'd0};
        push(1, 4'd9, 7'd2, 1'b0);
        send_elems(10, 2);
        wait_rsp(40);
        req = '0;

`ifdef SEARCH_TIMEOUT_EN
        // 6: watchdog response when done never comes.
        eng_lat = 0;
        req = 4'b0100;
        wait_gnt(2);
        push(2, 4'hF, 7'h7F, 1'b1);
        send_elems(10, 0);
        t = 0;
        while (!eng_ack && t < 1100) begin
            tick();
            t++;
        end
        check("t6_wd_cycles", 70'(t), 70'd1024);
        wait_rsp(5);
        req = '0;
`endif

        check("sb_empty", 70'(sb.size()), 70'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no end expected end");
        $fatal(1);
    end

endmodule

// File: doc/search_scheduler.md
Name: search_scheduler

Overview:
- Shares one minimum-search engine among NUM_REQ requesters.
- The engine takes 10 elements of 7 bits, a START/ACK handshake, and returns a location, a done flag and a cycle count.
- The scheduler grants requesters round-robin and collects the granted requester's 10 elements serially.
- It then sequences START, waits for done, pulses ACK, and returns location and cycle count to the requester through a valid/ready response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-low; 0 clears all state immediately.
- req, input, NUM_REQ, per-requester request; hold high until the response completes.
- gnt, output, NUM_REQ, one-hot grant; held from LOAD through the RESP handshake.
- elem_valid, input, 1, granted requester presents one element.
- elem_data, input, 7, element value; the k-th accepted element goes to slot k (0..9).
- eng_a, output, 70, packed elements to the engine; slot k occupies bits [7k+6:7k].
- eng_start, output, 1, engine START.
- eng_ack, output, 1, engine ACK.
- eng_done, input, 1, engine done flag.
- eng_location, input, 4, engine result index (15 = engine "none" code, passed through unchanged).
- eng_cycles, input, 7, engine cycle counter.
- rsp_valid, output, 1, response available.
- rsp_ready, input, 1, consumer accepts the response.
- rsp_id, output, ID_W, requester served.
- rsp_location, output, 4, captured eng_location.
- rsp_cycles, output, 7, captured eng_cycles.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset values: every output 0; eng_a 0; element counter 0; RR pointer = NUM_REQ-1, so requester 0 wins first. The engine's active-high reset is driven from ~reset at top level, so both blocks clear together.
- IDLE: if req is nonzero, grant the first set bit searching upward (modulo) from pointer+1.
  - Next cycle: gnt is registered one-hot, pointer updates to the winner, state goes to LOAD.
- LOAD: each cycle with elem_valid=1 writes elem_data to slot cnt and increments cnt.
  - Gaps in elem_valid are allowed.
  - After slot 9 is written, go to START.
  - If req[granted] drops during LOAD: drop gnt, return to IDLE, no engine activity, no response. The pointer stays at that requester, so the next arbitration starts past it.
- START: eng_start=1 for exactly one cycle, then WAIT.
  - eng_a is stable from the end of LOAD until the RESP handshake.
- WAIT: on eng_done=1, capture eng_location and eng_cycles into rsp_location and rsp_cycles, then go to ACK.
- ACK: eng_ack=1 for exactly one cycle, then RESP.
- RESP: rsp_valid=1 with rsp_id, rsp_location and rsp_cycles held stable until the cycle rsp_valid and rsp_ready are both 1.
  - Then gnt returns to 0, cnt returns to 0, and the state goes to IDLE.
  - No arbitration happens in the handshake cycle; the next grant comes one cycle later at the earliest.
- elem_valid outside LOAD is ignored. Simultaneous requests are resolved only by the RR pointer. req changes outside IDLE/LOAD are ignored.
- eng_start and eng_ack are never high together. Neither is high while reset=0.
- Minimum latency, with back-to-back elements and rsp_ready=1: grant edge, 10 LOAD cycles, 1 START, engine time, 1 ACK, 1 RESP.

Optional Feature:
- Macro: SEARCH_TIMEOUT_EN.
- Defined:
  - A 10-bit watchdog counts WAIT cycles. If it reaches 1023 without eng_done, the scheduler pulses eng_ack for one cycle and enters RESP with rsp_location=4'hF and rsp_cycles=7'h7F.
  - An extra output port rsp_err, 1 bit, is high with that response; reset value 0.
- Not defined: WAIT waits indefinitely; no watchdog logic and no rsp_err port.

Decomposition:
- Shared package search_pkg holds:
  - NUM_ELEM=10, ELEM_W=7, LOC_W=4, CYC_W=7, LOC_NONE=4'hF;
  - the state enum {IDLE, LOAD, START, WAIT, ACK, RESP};
  - TIMEOUT_MAX=1023.
- Sub-module rr_arbiter (NUM_REQ): takes req and pointer, returns a one-hot winner and its index. It is combinational; the registered pointer lives in search_scheduler.

Test Plan:
1. req=4'b0001; elements 50,40,30,20,10,60,70,80,90,100 sent back-to-back → eng_a[34:28]=10 and eng_a[69:63]=100. eng_start pulses once, 1 cycle after the 10th element. rsp_id=0, and rsp_location/rsp_cycles equal the engine model's values at done. eng_ack pulses once.
2. req=4'b1111 held, rsp_ready=1 → grants in order 0,1,2,3,0, each gnt one-hot, with at least one IDLE cycle between them.
3. Granted requester 2 sends 4 elements, then drops req → gnt goes to 0, eng_start never pulses, no rsp_valid. With req=4'b1001, the next grant is requester 3.
4. rsp_ready held 0 for 5 cycles in RESP → rsp_valid, rsp_id and rsp_location stay stable, with no new grant; release rsp_ready → IDLE next cycle.
5. reset driven 0 during WAIT → gnt, eng_start, eng_ack, rsp_valid and busy go to 0 without a clock edge. After release, req=4'b0010 is granted to requester 1 with the pointer reset.
6. With SEARCH_TIMEOUT_EN: eng_done held 0 → eng_ack pulses after 1023 WAIT cycles, then rsp_valid=1, rsp_err=1, rsp_location=15, rsp_cycles=127.
